// File: rtl/simd_pkg.sv
// simd_pkg
// Shared types and constants for the command dispatcher and its scoreboard.
//   cmd_t        : command word {op, dst, src_a, src_b}
//   OP_NOP       : consumed from the queue without touching any unit
//   OP_SYNC      : barrier, consumed only once every unit is idle
//   disp_state_t : dispatcher state, also exported for observation
package simd_pkg;

  localparam int CMD_ADDR_W = 18;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SYNC = 4'hF;

  typedef struct packed {
    logic [3:0]            op;
    logic [CMD_ADDR_W-1:0] dst;
    logic [CMD_ADDR_W-1:0] src_a;
    logic [CMD_ADDR_W-1:0] src_b;
  } cmd_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } disp_state_t;

  // True for opcodes that occupy a processing unit.
  function automatic logic is_exec_op(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_SYNC);
  endfunction

endpackage

// File: rtl/dispatch_scoreboard.sv
// dispatch_scoreboard
// Per-unit busy/destination table used by the dispatcher to find a free unit
// and to detect data hazards against commands still in flight.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears the table)
//   issue_onehot    : unit receiving a command at this edge (all-zero = none)
//   issue_dst       : destination address recorded for that unit
//   unit_done       : per-unit completion pulses; ignored on idle units
//   head_dst/src_a/src_b : operands of the current queue head
//   hazard          : some busy unit writes an address the head touches
//   any_busy        : at least one unit is busy
//   free_onehot     : lowest-index idle unit (all-zero when the pool is full)
// All outputs reflect the table as registered at the start of the cycle.
module dispatch_scoreboard
  import simd_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int ADDR_W  = CMD_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_UNITS-1:0] issue_onehot,
  input  logic [ADDR_W-1:0]  issue_dst,
  input  logic [N_UNITS-1:0] unit_done,
  input  logic [ADDR_W-1:0]  head_dst,
  input  logic [ADDR_W-1:0]  head_src_a,
  input  logic [ADDR_W-1:0]  head_src_b,
  output logic               hazard,
  output logic               any_busy,
  output logic [N_UNITS-1:0] free_onehot
);

  logic [N_UNITS-1:0] busy_q;
  logic [ADDR_W-1:0]  dst_q [N_UNITS];
  logic [N_UNITS-1:0] free_vec;

  // Issue only targets idle units, so a done pulse on the same unit in the
  // same cycle is necessarily spurious; letting the issue win is correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int k = 0; k < N_UNITS; k++) begin
        dst_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_UNITS; k++) begin
        if (issue_onehot[k]) begin
          busy_q[k] <= 1'b1;
          dst_q[k]  <= issue_dst;
        end else if (unit_done[k]) begin
          busy_q[k] <= 1'b0;
        end
      end
    end
  end

  // Exact base-address match against every in-flight destination covers
  // both read-after-write and write-after-write.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (busy_q[k] && ((dst_q[k] == head_dst) ||
                        (dst_q[k] == head_src_a) ||
                        (dst_q[k] == head_src_b))) begin
        hazard = 1'b1;
      end
    end
  end

  assign any_busy = |busy_q;
  assign free_vec = ~busy_q;
  // Isolate the lowest set bit: x & (-x).
  assign free_onehot = free_vec & (~free_vec + {{(N_UNITS-1){1'b0}}, 1'b1});

endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher
// Pulls commands from a first-word-fall-through queue and issues each one to
// the lowest-index idle processing unit, holding the head while it conflicts
// with an in-flight command. OP_SYNC waits for the whole pool to drain.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_queue_cmd      : queue head, valid while !i_queue_empty
//   i_queue_empty    : queue empty flag
//   o_rd_queue       : pop strobe (combinational), head advances next cycle
//   o_unit_valid     : registered one-hot issue pulse
//   o_unit_cmd       : command broadcast to the units alongside o_unit_valid
//   i_unit_done      : per-unit completion pulses
//   o_finished_task  : queue empty and pool idle (registered)
//   o_stall_cycles   : saturating count of cycles a valid head was held
//   o_dbg_state      : current dispatcher state
//
// Handshake: the queue side is valid/ready with valid = !i_queue_empty and
// ready = o_rd_queue; a transfer happens in a cycle where both are high and
// the FIFO presents the next word the following cycle. o_rd_queue never rises
// without valid and never depends on the head changing within the cycle.
module cmd_dispatcher
  import simd_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int ADDR_W  = CMD_ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  cmd_t               i_queue_cmd,
  input  logic               i_queue_empty,
  output logic               o_rd_queue,
  output logic [N_UNITS-1:0] o_unit_valid,
  output cmd_t               o_unit_cmd,
  input  logic [N_UNITS-1:0] i_unit_done,
  output logic               o_finished_task,
  output logic [31:0]        o_stall_cycles,
  output disp_state_t        o_dbg_state
);

  disp_state_t        state_q;
  disp_state_t        state_d;
  logic               head_valid;
  logic               hazard;
  logic               any_busy;
  logic [N_UNITS-1:0] free_onehot;
  logic [N_UNITS-1:0] issue_onehot;
  logic               rd_queue;
  logic [N_UNITS-1:0] unit_valid_q;
  cmd_t               unit_cmd_q;
  logic [31:0]        stall_q;

  assign head_valid = !i_queue_empty;

  dispatch_scoreboard #(
    .N_UNITS (N_UNITS),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk          (i_clk),
    .rst          (i_rst),
    .issue_onehot (issue_onehot),
    .issue_dst    (i_queue_cmd.dst),
    .unit_done    (i_unit_done),
    .head_dst     (i_queue_cmd.dst),
    .head_src_a   (i_queue_cmd.src_a),
    .head_src_b   (i_queue_cmd.src_b),
    .hazard       (hazard),
    .any_busy     (any_busy),
    .free_onehot  (free_onehot)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Only RUN decodes the head; a head that shows up in
  // DRAIN or DONE first moves the FSM back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!head_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (head_valid)     state_d = RUN;
        else if (!any_busy) state_d = DONE;
      end
      DONE: begin
        if (head_valid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output decode: pop strobe and the unit selected for this cycle's issue.
  always_comb begin
    rd_queue     = 1'b0;
    issue_onehot = '0;
    if (!i_rst && (state_q == RUN) && head_valid) begin
      if (i_queue_cmd.op == OP_NOP) begin
        rd_queue = 1'b1;
      end else if (i_queue_cmd.op == OP_SYNC) begin
        rd_queue = !any_busy;
      end else if (is_exec_op(i_queue_cmd.op) && !hazard && (free_onehot != '0)) begin
        rd_queue     = 1'b1;
        issue_onehot = free_onehot;
      end
    end
  end

  // Registered issue pulse, broadcast command and stall counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      unit_valid_q <= '0;
      unit_cmd_q   <= '0;
      stall_q      <= '0;
    end else begin
      unit_valid_q <= issue_onehot;
      if (issue_onehot != '0) begin
        unit_cmd_q <= i_queue_cmd;
      end
      if (head_valid && !rd_queue && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign o_rd_queue      = rd_queue;
  assign o_unit_valid    = unit_valid_q;
  assign o_unit_cmd      = unit_cmd_q;
  assign o_finished_task = (state_q == DONE);
  assign o_stall_cycles  = stall_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher
// Drives cmd_dispatcher from a FIFO model, predicts every pop, issue pulse,
// finished flag and stall count from the dispatcher's behavioural rules, and
// checks issue pulses in a separate monitor through an expected queue.
module tb_cmd_dispatcher;
  import simd_pkg::*;

  localparam int N     = 4;
  localparam int CW    = $bits(cmd_t);
  localparam int EXP_W = 32 + N + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  cmd_t        q_cmd;
  logic        q_empty;
  logic        rd;
  logic [N-1:0] uv;
  cmd_t        ucmd;
  logic [N-1:0] udone;
  logic        fin;
  logic [31:0] stall;
  disp_state_t dbg_state;

  cmd_dispatcher #(
    .N_UNITS (N),
    .ADDR_W  (CMD_ADDR_W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_queue_cmd     (q_cmd),
    .i_queue_empty   (q_empty),
    .o_rd_queue      (rd),
    .o_unit_valid    (uv),
    .o_unit_cmd      (ucmd),
    .i_unit_done     (udone),
    .o_finished_task (fin),
    .o_stall_cycles  (stall),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic started = 1'b0;

  cmd_t fifo_q[$];
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: which units hold work, what they write, and the
  // externally visible counters.
  logic [N-1:0]          m_busy;
  logic [CMD_ADDR_W-1:0] m_dst [N];
  logic [31:0]           m_stall;
  int                    m_empty_run;  // consecutive empty, non-reset cycles
  logic                  m_can_decode; // head was present last cycle, or just out of reset
  logic                  m_fin;
  logic                  m_known = 1'b0;
  logic                  dut_pop;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [3:0] op, input int d, input int a, input int b);
    cmd_t c;
    c.op    = op;
    c.dst   = CMD_ADDR_W'(d);
    c.src_a = CMD_ADDR_W'(a);
    c.src_b = CMD_ADDR_W'(b);
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    int   r;
    logic [3:0] op;
    r = $urandom_range(0, 19);
    if (r < 2)       op = OP_NOP;
    else if (r == 2) op = OP_SYNC;
    else             op = 4'($urandom_range(1, 14));
    return mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
  endfunction

  // ---------------- reference model step (called mid-cycle) ----------------
  task automatic model_step();
    logic pop;
    int   unit;
    logic haz;
    logic idle_now;
    cmd_t h;
    if (rst) begin
      check("rd_queue_in_reset", 96'(rd), 96'(0));
      m_busy       = '0;
      m_stall      = '0;
      m_empty_run  = 0;
      m_can_decode = 1'b1;
      m_fin        = 1'b0;
      m_known      = 1'b1;
      return;
    end
    if (m_known) begin
      check("finished_task", 96'(fin), 96'(m_fin));
      check("stall_cycles", 96'(stall), 96'(m_stall));
    end
    h    = q_cmd;
    pop  = 1'b0;
    unit = -1;
    if (!q_empty && m_can_decode) begin
      if (h.op == OP_NOP) begin
        pop = 1'b1;
      end else if (h.op == OP_SYNC) begin
        pop = (m_busy == '0);
      end else begin
        haz = 1'b0;
        for (int k = 0; k < N; k++)
          if (m_busy[k] && (m_dst[k] == h.dst || m_dst[k] == h.src_a || m_dst[k] == h.src_b))
            haz = 1'b1;
        if (!haz) begin
          for (int k = N - 1; k >= 0; k--)
            if (!m_busy[k]) unit = k;
        end
        if (unit >= 0) pop = 1'b1;
      end
    end
    check("rd_queue", 96'(rd), 96'(pop));
    if (unit >= 0) exp_q.push_back({32'(cyc), N'(1 << unit), h});
    if (!q_empty && !pop && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    idle_now = (m_busy == '0);
    for (int k = 0; k < N; k++) begin
      if (k == unit) begin
        m_busy[k] = 1'b1;
        m_dst[k]  = h.dst;
      end else if (udone[k]) begin
        m_busy[k] = 1'b0;
      end
    end
    m_empty_run  = q_empty ? m_empty_run + 1 : 0;
    m_fin        = q_empty && (m_empty_run >= 2) && idle_now;
    m_can_decode = !q_empty;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic r, input logic [N-1:0] d);
    rst     = r;
    udone   = d;
    q_empty = (fifo_q.size() == 0);
    q_cmd   = q_empty ? '0 : fifo_q[0];
    @(negedge clk);
    model_step();
    dut_pop = rd;
    @(posedge clk);
    #1;
    cyc++;
    if (dut_pop === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0);
  endtask

  // Finish everything queued, completing busy units at random, then idle.
  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (fifo_q.size() == 0 && m_busy == '0) break;
      tick(1'b0, m_busy & N'($urandom_range(0, (1 << N) - 1)));
    end
    idle(4);
  endtask

  task automatic rand_phase(input int n, input int push_pct, input int done_pct);
    logic [N-1:0] d;
    for (int i = 0; i < n; i++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 99) < push_pct) fifo_q.push_back(rand_cmd());
      for (int k = 0; k < N; k++) d[k] = ($urandom_range(0, 99) < done_pct);
      tick(1'b0, d);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EXP_W-1:0] mon_item;
  always @(negedge clk) begin
    if (started) begin
      if (uv !== '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 96'(uv), 96'(0));
        end else begin
          mon_item = exp_q.pop_front();
          check("issue_latency", 96'(cyc), 96'(mon_item[EXP_W-1 -: 32]) + 96'd1);
          check("issue_unit", 96'(uv), 96'(mon_item[CW +: N]));
          check("issue_cmd", 96'(ucmd), 96'(mon_item[CW-1:0]));
        end
      end else if (exp_q.size() != 0) begin
        mon_item = exp_q[0];
        if (int'(mon_item[EXP_W-1 -: 32]) + 1 <= cyc) begin
          void'(exp_q.pop_front());
          check("missing_issue", 96'(uv), 96'(mon_item[CW +: N]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    udone   = '0;
    q_empty = 1'b1;
    q_cmd   = '0;
    @(posedge clk);
    #1;
    tick(1'b1, '0);
    tick(1'b1, '0);
    started = 1'b1;
    check("reset_unit_valid", 96'(uv), 96'(0));
    check("reset_unit_cmd", 96'(ucmd), 96'(0));
    check("reset_finished", 96'(fin), 96'(0));
    check("reset_stall", 96'(stall), 96'(0));
    idle(4);

    // Independent stream: four issue back to back, the fifth waits for a done.
    for (int i = 1; i <= 5; i++) fifo_q.push_back(mk(4'h1, i, 'h100 + i, 'h200 + i));
    idle(8);
    tick(1'b0, 4'b0010);
    idle(3);
    drain();

    // RAW hazard on address 0x10.
    fifo_q.push_back(mk(4'h2, 'h10, 'h30, 'h31));
    fifo_q.push_back(mk(4'h3, 'h40, 'h10, 'h32));
    idle(5);
    tick(1'b0, 4'b0001);
    idle(3);
    drain();

    // Barrier behind two in-flight commands.
    fifo_q.push_back(mk(4'h4, 'h50, 'h51, 'h52));
    fifo_q.push_back(mk(4'h5, 'h60, 'h61, 'h62));
    fifo_q.push_back(mk(OP_SYNC, 0, 0, 0));
    fifo_q.push_back(mk(4'h6, 'h70, 'h71, 'h72));
    idle(4);
    tick(1'b0, 4'b0011);
    idle(4);
    drain();

    // NOP and a spurious done on an idle unit.
    fifo_q.push_back(mk(OP_NOP, 'h80, 'h81, 'h82));
    fifo_q.push_back(mk(4'h7, 'h90, 'h91, 'h92));
    idle(2);
    tick(1'b0, 4'b1000);
    fifo_q.push_back(mk(4'h8, 'hA0, 'hA1, 'hA2));
    idle(3);
    drain();

    // Reset with three units busy and a hazarding head waiting.
    for (int i = 0; i < 3; i++) fifo_q.push_back(mk(4'h9, 'hB0 + i, 'hC0 + i, 'hD0 + i));
    idle(4);
    fifo_q.push_back(mk(4'hA, 'hE0, 'hB0, 'hE1));
    idle(3);
    tick(1'b1, '0);
    check("midrst_unit_valid", 96'(uv), 96'(0));
    check("midrst_unit_cmd", 96'(ucmd), 96'(0));
    check("midrst_finished", 96'(fin), 96'(0));
    check("midrst_stall", 96'(stall), 96'(0));
    idle(3);
    drain();

    // Randomized traffic with hazard-prone addresses and random dones.
    for (int r = 0; r < 6; r++) begin
      rand_phase(400, 30 + 10 * r, 10 + 5 * r);
      drain();
    end

    idle(3);
    check("exp_q_empty", 96'(exp_q.size()), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
